// File: rtl/tdc_frame_ctrl_if.sv
// TDC stream and frame-result handshake between tdc_frame_ctrl, tdc_top and the core logic.
interface tdc_frame_ctrl_if;
    logic        TDC_start;
    logic        TDC_INT;
    logic [14:0] TDC_Odata;
    logic [4:0]  TDC_Oint;
    logic [1:0]  TDC_Onum;
    logic        TDC_Olast;
    logic        TDC_Ovalid;
    logic        TDC_Oready;
    logic [14:0] res_depth;
    logic [4:0]  res_int;
    logic [7:0]  res_hits;
    logic [7:0]  res_tmo;
    logic        res_valid;
    logic        res_ready;

    // Sequencer side
    modport master (
        output TDC_start, TDC_Oready,
        output res_depth, res_int, res_hits, res_tmo, res_valid,
        input  TDC_INT, TDC_Odata, TDC_Oint, TDC_Onum, TDC_Olast, TDC_Ovalid,
        input  res_ready
    );

    // tdc_top / core-logic side
    modport slave (
        input  TDC_start, TDC_Oready,
        input  res_depth, res_int, res_hits, res_tmo, res_valid,
        output TDC_INT, TDC_Odata, TDC_Oint, TDC_Onum, TDC_Olast, TDC_Ovalid,
        output res_ready
    );
endinterface

// File: rtl/tdc_frame_ctrl.sv
// Frame sequencer: fires cfg_shots TDC shots, drains each shot's beat stream,
// keeps the highest-intensity sample and hands one result to the core logic.
module tdc_frame_ctrl #(
    parameter int unsigned START_LEN = 2,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_en,
    input  logic [7:0] cfg_shots,
    input  logic       frame_req,
    output logic       busy,
    tdc_frame_ctrl_if.master bus
);

    localparam int unsigned SLW = $clog2(START_LEN) + 1;
    localparam int unsigned TMW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        NEXT,
        RESULT
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       shots_q, shots_d;
    logic [7:0]       shot_cnt_q, shot_cnt_d;
    logic [SLW-1:0]   start_cnt_q, start_cnt_d;
    logic [TMW-1:0]   timer_q, timer_d;
    logic             got_q, got_d;
    logic [14:0]      best_depth_q, best_depth_d;
    logic [4:0]       best_int_q, best_int_d;
    logic [7:0]       hits_q, hits_d;
    logic [7:0]       tmo_q, tmo_d;
    logic             start_q, start_d;
    logic             oready_q, oready_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             beat_acc;
    logic             shot_end;
    logic             unused_onum;

    // Beat count is informational only
    always_comb unused_onum = ^bus.TDC_Onum;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state, datapath updates and registered-output decode
    always_comb begin
        state_d      = state_q;
        shots_d      = shots_q;
        shot_cnt_d   = shot_cnt_q;
        start_cnt_d  = start_cnt_q;
        timer_d      = timer_q;
        got_d        = got_q;
        best_depth_d = best_depth_q;
        best_int_d   = best_int_q;
        hits_d       = hits_q;
        tmo_d        = tmo_q;
        beat_acc     = bus.TDC_Ovalid && oready_q;
        shot_end     = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_req && cfg_en) begin
                    shots_d      = (cfg_shots == 8'd0) ? 8'd1 : cfg_shots;
                    shot_cnt_d   = '0;
                    start_cnt_d  = '0;
                    best_depth_d = '0;
                    best_int_d   = '0;
                    hits_d       = '0;
                    tmo_d        = '0;
                    state_d      = START;
                end
            end
            START: begin
                timer_d = '0;
                got_d   = 1'b0;
                if (!cfg_en) begin
                    state_d = IDLE;
                end else if (start_cnt_q == SLW'(START_LEN - 1)) begin
                    state_d = WAIT;
                end else begin
                    start_cnt_d = start_cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (!cfg_en) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (beat_acc) begin
                        got_d = 1'b1;
                        if (bus.TDC_Oint > best_int_q) begin
                            best_depth_d = bus.TDC_Odata;
                            best_int_d   = bus.TDC_Oint;
                        end
                    end
                    // Last beat beats an empty INT end, which beats a timeout
                    if (beat_acc && bus.TDC_Olast) begin
                        shot_end = 1'b1;
                    end else if (bus.TDC_INT && !got_q && !bus.TDC_Ovalid) begin
                        shot_end = 1'b1;
                    end else if (timer_q == TMW'(TIMEOUT - 1)) begin
                        shot_end = 1'b1;
                        if (tmo_q != 8'hFF) tmo_d = tmo_q + 1'b1;
                    end
                    if (shot_end) begin
                        state_d = NEXT;
                        if ((got_q || beat_acc) && hits_q != 8'hFF) hits_d = hits_q + 1'b1;
                    end
                end
            end
            NEXT: begin
                if (!cfg_en) begin
                    state_d = IDLE;
                end else if (shot_cnt_q == shots_q - 8'd1) begin
                    state_d = RESULT;
                end else begin
                    shot_cnt_d  = shot_cnt_q + 1'b1;
                    start_cnt_d = '0;
                    state_d     = START;
                end
            end
            RESULT: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        start_d  = (state_d == START);
        oready_d = (state_d == WAIT);
        valid_d  = (state_d == RESULT);
        busy_d   = (state_d != IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shots_q      <= '0;
            shot_cnt_q   <= '0;
            start_cnt_q  <= '0;
            timer_q      <= '0;
            got_q        <= 1'b0;
            best_depth_q <= '0;
            best_int_q   <= '0;
            hits_q       <= '0;
            tmo_q        <= '0;
            start_q      <= 1'b0;
            oready_q     <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            shots_q      <= shots_d;
            shot_cnt_q   <= shot_cnt_d;
            start_cnt_q  <= start_cnt_d;
            timer_q      <= timer_d;
            got_q        <= got_d;
            best_depth_q <= best_depth_d;
            best_int_q   <= best_int_d;
            hits_q       <= hits_d;
            tmo_q        <= tmo_d;
            start_q      <= start_d;
            oready_q     <= oready_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
        end
    end

    // Result buses are the frame accumulators; they only move outside RESULT
    always_comb begin
        bus.TDC_start  = start_q;
        bus.TDC_Oready = oready_q;
        bus.res_valid  = valid_q;
        bus.res_depth  = best_depth_q;
        bus.res_int    = best_int_q;
        bus.res_hits   = hits_q;
        bus.res_tmo    = tmo_q;
        busy           = busy_q;
    end

endmodule

// File: tb/tb_tdc_frame_ctrl.sv
// Scoreboard bench for tdc_frame_ctrl: a frame-level reference model predicts
// each result, a monitor compares whatever the DUT presents on res_valid.
module tb_tdc_frame_ctrl;

    localparam int unsigned START_LEN = 2;
    localparam int unsigned TIMEOUT   = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cfg_en = 1'b0;
    logic [7:0] cfg_shots = '0;
    logic       frame_req = 1'b0;
    logic       busy;

    tdc_frame_ctrl_if bus ();

    tdc_frame_ctrl #(.START_LEN(START_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_en    (cfg_en),
        .cfg_shots (cfg_shots),
        .frame_req (frame_req),
        .busy      (busy),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // kind: 0 beats ending in last, 1 empty INT end, 2 silent timeout, 3 beats without last (timeout)
    typedef struct packed {
        logic [1:0]       kind;
        logic [2:0]       nb;
        logic [2:0]       gap;
        logic [4:0]       pre;
        logic [3:0][14:0] d;
        logic [3:0][4:0]  it;
    } shot_t;

    typedef struct packed {
        logic [14:0] depth;
        logic [4:0]  inten;
        logic [7:0]  hits;
        logic [7:0]  tmo;
    } res_t;

    shot_t frame_shots[$];
    res_t  exp_q[$];
    int    checks = 0;
    int    passed = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Frame result from the rules: strictly-higher intensity wins, hit = shot with any beat
    function automatic res_t model_frame();
        res_t r;
        r = '0;
        foreach (frame_shots[i]) begin
            for (int b = 0; b < int'(frame_shots[i].nb); b++) begin
                if (frame_shots[i].it[b] > r.inten) begin
                    r.inten = frame_shots[i].it[b];
                    r.depth = frame_shots[i].d[b];
                end
            end
            if (frame_shots[i].nb != 0) r.hits = r.hits + 8'd1;
            if (frame_shots[i].kind >= 2) r.tmo = r.tmo + 8'd1;
        end
        return r;
    endfunction

    function automatic shot_t mk(input int kind, input int nb, input int pre, input int gap);
        shot_t s;
        s = '0;
        s.kind = 2'(kind);
        s.nb   = 3'(nb);
        s.pre  = 5'(pre);
        s.gap  = 3'(gap);
        return s;
    endfunction

    function automatic shot_t rand_shot();
        shot_t s;
        int k;
        k = int'($urandom_range(0, 3));
        s = mk(k, (k == 0 || k == 3) ? int'($urandom_range(1, 4)) : 0,
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        for (int b = 0; b < 4; b++) begin
            s.d[b]  = 15'($urandom);
            s.it[b] = 5'($urandom_range(0, 31));
        end
        return s;
    endfunction

    task automatic run_shot(input shot_t s);
        int n;
        int w;
        n = 0;
        while (!bus.TDC_start && n < 40) begin @(negedge clk); n++; end
        if (!bus.TDC_start) begin
            check("start_seen", 0, 1);
            return;
        end
        n = 0;
        while (bus.TDC_start && n < 40) begin @(negedge clk); n++; end
        check("start_len", n, START_LEN);
        check("oready_in_wait", bus.TDC_Oready, 1);
        w = 0;
        repeat (int'(s.pre)) begin @(negedge clk); w++; end
        if (s.kind == 1) begin
            bus.TDC_INT = 1'b1;
            @(negedge clk);
            bus.TDC_INT = 1'b0;
            check("oready_drop_int", bus.TDC_Oready, 0);
        end else if (s.kind == 0 || s.kind == 3) begin
            for (int b = 0; b < int'(s.nb); b++) begin
                if (b > 0) repeat (int'(s.gap)) begin @(negedge clk); w++; end
                bus.TDC_Ovalid = 1'b1;
                bus.TDC_Odata  = s.d[b];
                bus.TDC_Oint   = s.it[b];
                bus.TDC_Onum   = 2'($urandom);
                bus.TDC_Olast  = (s.kind == 0 && b == int'(s.nb) - 1);
                @(negedge clk);
                w++;
                // Junk on the data lines while invalid must never be picked up
                bus.TDC_Ovalid = 1'b0;
                bus.TDC_Olast  = 1'b0;
                bus.TDC_Odata  = 15'($urandom);
                bus.TDC_Oint   = 5'd31;
            end
            if (s.kind == 0) check("oready_drop_last", bus.TDC_Oready, 0);
        end
        if (s.kind >= 2) begin
            while (bus.TDC_Oready && w < 60) begin @(negedge clk); w++; end
            check("wait_len", w, TIMEOUT);
        end
    endtask

    task automatic run_frame(input logic [7:0] shots_cfg, input int hold, input bit req_in_result);
        int n;
        exp_q.push_back(model_frame());
        cfg_shots = shots_cfg;
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        cfg_shots = 8'($urandom);
        check("busy_after_req", busy, 1);
        foreach (frame_shots[i]) run_shot(frame_shots[i]);
        n = 0;
        while (!bus.res_valid && n < 20) begin @(negedge clk); n++; end
        check("result_latency", n, 1);
        repeat (hold) begin
            frame_req = req_in_result;
            @(negedge clk);
        end
        frame_req = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("valid_drop", bus.res_valid, 0);
        check("idle_after_ack", busy, 0);
        if (req_in_result) begin
            repeat (3) @(negedge clk);
            check("req_ignored", busy, 0);
        end
    endtask

    task automatic random_frame(input int hold);
        logic [7:0] c;
        int ns;
        c  = 8'($urandom_range(0, 5));
        ns = (c == 0) ? 1 : int'(c);
        frame_shots.delete();
        for (int i = 0; i < ns; i++) frame_shots.push_back(rand_shot());
        run_frame(c, hold, 1'b0);
    endtask

    // Monitor: compare each presented result against the scoreboard, then watch it stay put
    initial begin
        res_t cur;
        res_t cap;
        res_t e;
        bit   shown;
        bit   unstable;
        shown    = 1'b0;
        unstable = 1'b0;
        cap      = '0;
        forever begin
            @(negedge clk);
            cur = {bus.res_depth, bus.res_int, bus.res_hits, bus.res_tmo};
            if (!rst_n) begin
                shown = 1'b0;
            end else if (bus.res_valid && !shown) begin
                shown    = 1'b1;
                unstable = 1'b0;
                cap      = cur;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_depth", cur.depth, e.depth);
                    check("res_int", cur.inten, e.inten);
                    check("res_hits", cur.hits, e.hits);
                    check("res_tmo", cur.tmo, e.tmo);
                end
            end else if (bus.res_valid) begin
                if (cur != cap) unstable = 1'b1;
            end else if (shown) begin
                shown = 1'b0;
                check("res_stable", unstable, 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        shot_t s;
        bus.TDC_INT    = 1'b0;
        bus.TDC_Odata  = '0;
        bus.TDC_Oint   = '0;
        bus.TDC_Onum   = '0;
        bus.TDC_Olast  = 1'b0;
        bus.TDC_Ovalid = 1'b0;
        bus.res_ready  = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_start", bus.TDC_start, 0);
        check("rst_oready", bus.TDC_Oready, 0);
        check("rst_valid", bus.res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_depth", bus.res_depth, 0);
        check("rst_int", bus.res_int, 0);
        check("rst_hits", bus.res_hits, 0);
        check("rst_tmo", bus.res_tmo, 0);
        rst_n  = 1'b1;
        cfg_en = 1'b1;
        @(negedge clk);

        // One shot, higher-intensity later beat wins
        frame_shots.delete();
        s = mk(0, 2, 0, 0);
        s.d[0] = 15'd100; s.it[0] = 5'd1;
        s.d[1] = 15'd200; s.it[1] = 5'd5;
        frame_shots.push_back(s);
        run_frame(8'd1, 0, 1'b0);

        // Three shots, intensity tie keeps the earlier sample
        frame_shots.delete();
        s = mk(0, 1, 0, 0); s.d[0] = 15'd300; s.it[0] = 5'd9;  frame_shots.push_back(s);
        s = mk(0, 1, 1, 0); s.d[0] = 15'd400; s.it[0] = 5'd11; frame_shots.push_back(s);
        s = mk(0, 1, 2, 0); s.d[0] = 15'd500; s.it[0] = 5'd11; frame_shots.push_back(s);
        run_frame(8'd3, 1, 1'b0);

        // Two silent shots, both time out
        frame_shots.delete();
        frame_shots.push_back(mk(2, 0, 0, 0));
        frame_shots.push_back(mk(2, 0, 0, 0));
        run_frame(8'd2, 0, 1'b0);

        // Empty INT end followed by a delivering shot
        frame_shots.delete();
        frame_shots.push_back(mk(1, 0, 1, 0));
        s = mk(0, 1, 0, 0); s.d[0] = 15'd250; s.it[0] = 5'd8; frame_shots.push_back(s);
        run_frame(8'd2, 2, 1'b0);

        // Last beat on the final timer cycle is a normal end
        frame_shots.delete();
        s = mk(0, 1, int'(TIMEOUT) - 1, 0); s.d[0] = 15'd77; s.it[0] = 5'd3;
        frame_shots.push_back(s);
        run_frame(8'd0, 0, 1'b0);

        // Abort mid-WAIT
        cfg_shots = 8'd3;
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        n = 0;
        while (!bus.TDC_Oready && n < 20) begin @(negedge clk); n++; end
        check("abort_reach_wait", bus.TDC_Oready, 1);
        repeat (2) @(negedge clk);
        cfg_en = 1'b0;
        @(negedge clk);
        check("abort_oready", bus.TDC_Oready, 0);
        check("abort_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("abort_no_valid", bus.res_valid, 0);
        cfg_en = 1'b1;
        random_frame(1);

        // Long stall in RESULT with frame_req ignored
        frame_shots.delete();
        s = mk(0, 2, 0, 1);
        s.d[0] = 15'd1234; s.it[0] = 5'd20;
        s.d[1] = 15'd4321; s.it[1] = 5'd19;
        frame_shots.push_back(s);
        run_frame(8'd1, 10, 1'b1);

        // Asynchronous reset in START
        cfg_shots = 8'd1;
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        check("pre_reset_start", bus.TDC_start, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_start", bus.TDC_start, 0);
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", busy, 0);

        for (int f = 0; f < 20; f++) random_frame(int'($urandom_range(0, 3)));

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tdc_frame_ctrl.md
# tdc_frame_ctrl

Frame sequencer for `tdc_top`. On each frame request it fires a programmable number of TDC shots by pulsing `TDC_start`. It drains the TDC output stream for each shot and keeps the highest-intensity depth sample across the frame. It then presents one frame result to the core logic over a valid/ready handshake. It sits between the core logic and `tdc_top`, in the 250 MHz `clk` domain.

## Interface
Parameters:
- `START_LEN`, 2: cycles `TDC_start` is held high per shot (≥1).
- `TIMEOUT`, 1024: maximum `WAIT` cycles per shot before the shot is abandoned (≥2).

Ports:
- `clk`, input, 1: 250 MHz logic clock; sole clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `cfg_en`, input, 1: sequencer enable; low aborts any frame in progress.
- `cfg_shots`, input, 8: shots per frame; 0 is treated as 1; latched at frame start.
- `frame_req`, input, 1: frame start request, sampled in `IDLE` only.
- `TDC_start`, output, 1: shot start to `tdc_top`.
- `TDC_INT`, input, 1: TDC interrupt; marks shot end with no data.
- `TDC_Odata`, input, 15: depth sample.
- `TDC_Oint`, input, 5: intensity of the sample.
- `TDC_Onum`, input, 2: valid data count; not used for decisions.
- `TDC_Olast`, input, 1: last beat of the shot.
- `TDC_Ovalid`, input, 1: beat valid.
- `TDC_Oready`, output, 1: beat ready.
- `res_depth`, output, 15: depth of the best sample in the frame.
- `res_int`, output, 5: intensity of the best sample.
- `res_hits`, output, 8: number of shots that delivered at least one beat.
- `res_tmo`, output, 8: number of shots ended by timeout.
- `res_valid`, output, 1: result valid.
- `res_ready`, input, 1: result accepted.
- `busy`, output, 1: high in every state except `IDLE`.

## Operation
- All outputs are registered. Reset values: `TDC_start` 0, `TDC_Oready` 0, `res_valid` 0, `busy` 0, and all `res_*` buses 0. State resets to `IDLE`.
- A beat is accepted when `TDC_Ovalid && TDC_Oready`.

State machine:
- **`IDLE`**
  - On `frame_req && cfg_en`: latch shots = max(`cfg_shots`,1); clear `shot_cnt`, best depth/int, hit count and timeout count; go to `START`.
  - `frame_req` in any other state is ignored.
- **`START`**
  - `TDC_start` is high for exactly `START_LEN` cycles, then go to `WAIT`.
  - The WAIT timer and the per-shot "got beat" flag are cleared.
- **`WAIT`**
  - `TDC_Oready` is high; the timer increments each cycle.
  - For each accepted beat:
    - set the got-beat flag;
    - if `TDC_Oint` > best_int (strictly greater), load best_depth ← `TDC_Odata` and best_int ← `TDC_Oint`. On a tie the earlier sample is kept.
  - The shot ends on the first of the following, in priority order:
    1. an accepted beat with `TDC_Olast` is a normal end;
    2. `TDC_INT` high with no beat in progress (got-beat flag clear and `TDC_Ovalid` low) is an empty end;
    3. timer == `TIMEOUT`-1 is a timeout end, and the timeout count increments.
  - The hit count increments at shot end if the got-beat flag is set, including a beat accepted in the final cycle.
  - Every end goes to `NEXT`.
- **`NEXT`**
  - If `shot_cnt` == shots-1, go to `RESULT`.
  - Otherwise increment `shot_cnt` and go to `START`.
- **`RESULT`**
  - `res_valid` is high; all `res_*` buses are stable until handshake.
  - On `res_ready`, go to `IDLE`; `res_valid` drops the next cycle.
- **Abort:** `cfg_en` low in `START`, `WAIT` or `NEXT` moves to `IDLE` the next cycle. `TDC_start` and `TDC_Oready` drop, and no result is produced. `cfg_en` low in `RESULT` does not abort the pending result.
- Counters saturate at 255; `shot_cnt` cannot exceed 254 by construction.
- A frame in which no beat is accepted returns `res_depth` 0 and `res_int` 0.

## Timing
- `frame_req` sampled at cycle 0 → `TDC_start` high in cycles 1..`START_LEN` → `WAIT` (`TDC_Oready` high) from cycle `START_LEN`+1.
- Shot-ending event at cycle k → `NEXT` at k+1 → next `TDC_start` high at k+2, or `res_valid` high at k+2 on the last shot.
- `TDC_Oready` drops in the cycle after a shot end. Beats arriving outside `WAIT` are not accepted.
- Minimum frame length with one shot and an immediate `TDC_Olast` beat: `START_LEN`+3 cycles from `frame_req` to `res_valid`.
- Async reset mid-frame: all outputs return to their reset values immediately and the state returns to `IDLE`.

## Test plan
1. `cfg_shots`=1; beats (100,int1) then (200,int5,last) → one `TDC_start` of 2 cycles; `res_depth`=200, `res_int`=5, `res_hits`=1, `res_tmo`=0.
2. `cfg_shots`=3; the shots' single last beats are (300,9), (400,11), (500,11) → three start pulses; `res_depth`=400 (tie keeps the earlier sample), `res_int`=11, `res_hits`=3.
3. `TIMEOUT`=16, `cfg_shots`=2, no beats and no `TDC_INT` → each `WAIT` lasts 16 cycles; `res_hits`=0, `res_tmo`=2, `res_depth`=0, `res_int`=0.
4. `cfg_shots`=2; shot 1 ends with `TDC_INT` only, shot 2 delivers (250,int8,last) → `res_hits`=1, `res_tmo`=0, `res_depth`=250. In a separate cycle-level check, a last beat and timer == `TIMEOUT`-1 in the same cycle → normal end, `res_tmo` not incremented.
5. `cfg_en` dropped mid-`WAIT` → `IDLE` next cycle, `TDC_Oready`=0, `res_valid` never asserts. A subsequent `frame_req` starts a clean frame.
6. `res_ready` held low for 10 cycles in `RESULT` → `res_*` stable and `frame_req` ignored. Then a `res_ready` pulse → `IDLE`. Then `rst_n` asserted mid-`START` → `TDC_start`=0 asynchronously.
